// File: rtl/lcd_channel_writer_pkg.sv
// Shared definitions for the LCD channel writer: FSM states, HD44780 command
// bytes, ASCII digit bases and small formatting helpers.
package lcd_channel_writer_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ADDR,
    ST_CHAR,
    ST_EN_HIGH,
    ST_EN_LOW_WAIT,
    ST_DONE
  } state_t;

  localparam logic [7:0] CMD_FUNC_SET   = 8'h38;
  localparam logic [7:0] CMD_DISPLAY_ON = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_SET_ADDR   = 8'h80;

  localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
  localparam logic [7:0] ASCII_ALPHA_BASE = 8'h41;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISPLAY_ON;
      2'd2:    return CMD_ENTRY_MODE;
      default: return CMD_CLEAR;
    endcase
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ASCII_DIGIT_BASE + {4'h0, nib};
    else             return ASCII_ALPHA_BASE + {4'h0, nib - 4'd10};
  endfunction

  // Even channels land on line 1, odd channels on line 2, pairs 8 columns apart.
  function automatic logic [7:0] chan_addr_cmd(input int unsigned c);
    return CMD_SET_ADDR | 8'(((c % 2) * 64) + ((c / 2) * 8));
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/lcd_channel_writer_sender.sv
// HD44780 byte timing: one setup clock, enable high, then a short or long
// post-byte wait before accepting the next byte.
module lcd_byte_sender
  import lcd_channel_writer_pkg::*;
#(
  parameter int unsigned EN_HIGH_CYCLES    = 12,
  parameter int unsigned WAIT_CYCLES       = 2500,
  parameter int unsigned CLEAR_WAIT_CYCLES = 100000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_rs_in,
  input  logic [7:0] i_byte_in,
  input  logic       i_long_wait,
  output logic       o_ready,
  output logic       o_enable,
  output logic       o_rs,
  output logic [7:0] o_lcd_data
);

  localparam int unsigned MAX_WAIT = max3(EN_HIGH_CYCLES, WAIT_CYCLES, CLEAR_WAIT_CYCLES);
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {SND_READY, SND_SETUP, SND_HIGH, SND_WAIT} snd_t;

  snd_t             r_phase, w_phase_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_wait_last;
  logic             r_rs, r_long;
  logic [7:0]       r_byte;

  assign w_wait_last = r_long ? CNT_W'(CLEAR_WAIT_CYCLES - 1) : CNT_W'(WAIT_CYCLES - 1);

  always_comb begin
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    case (r_phase)
      SND_READY: if (i_start) begin
        w_phase_nxt = SND_SETUP;
        w_cnt_nxt   = '0;
      end
      SND_SETUP: begin
        w_phase_nxt = SND_HIGH;
        w_cnt_nxt   = '0;
      end
      SND_HIGH: begin
        if (r_cnt == CNT_W'(EN_HIGH_CYCLES - 1)) begin
          w_phase_nxt = SND_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      SND_WAIT: begin
        if (r_cnt == w_wait_last) begin
          w_phase_nxt = SND_READY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_phase_nxt = SND_READY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= SND_READY;
      r_cnt   <= '0;
      r_rs    <= 1'b0;
      r_long  <= 1'b0;
      r_byte  <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_phase == SND_READY && i_start) begin
        r_rs   <= i_rs_in;
        r_byte <= i_byte_in;
        r_long <= i_long_wait;
      end
    end
  end

  assign o_ready    = (r_phase == SND_READY);
  assign o_enable   = (r_phase == SND_HIGH);
  assign o_rs       = r_rs;
  assign o_lcd_data = r_byte;

endmodule

// File: rtl/lcd_channel_writer.sv
// Multi-channel HD44780 writer: power-up init, lowest-index arbitration of
// display requests, and binary/hex formatting of each channel's value.
module lcd_channel_writer
  import lcd_channel_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned NUM_CHANNELS      = 2,
  parameter int unsigned HEX_MODE          = 0,
  parameter int unsigned EN_HIGH_CYCLES    = 12,
  parameter int unsigned WAIT_CYCLES       = 2500,
  parameter int unsigned CLEAR_WAIT_CYCLES = 100000
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [NUM_CHANNELS-1:0]              i_show,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   i_data,
  output logic                                 o_busy,
  output logic [NUM_CHANNELS-1:0]              o_done,
  output logic                                 o_enable,
  output logic                                 o_rs,
  output logic                                 o_rw,
  output logic                                 o_on,
  output logic [7:0]                           o_lcd_data
);

  localparam int unsigned HEX_DIGITS = (DATA_WIDTH + 3) / 4;
  localparam int unsigned NUM_DIGITS = (HEX_MODE != 0) ? HEX_DIGITS : DATA_WIDTH;
  localparam int unsigned DIG_W      = $clog2(NUM_DIGITS + 1);
  localparam int unsigned CH_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  state_t                  r_state, w_state_nxt;
  logic                    r_init_mode;
  logic [1:0]              r_init_idx;
  logic [NUM_CHANNELS-1:0] r_pending, r_show_d, w_set, w_clr;
  logic [CH_W-1:0]         r_chan, w_sel;
  logic                    w_any;
  logic [DATA_WIDTH-1:0]   r_snap, w_slice;
  logic [DIG_W-1:0]        r_digits;
  logic                    r_en_d;
  logic                    w_start, w_rs, w_long, w_ready, w_enable;
  logic [7:0]              w_byte, w_char;

  always_comb begin
    w_any   = 1'b0;
    w_sel   = '0;
    w_slice = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (r_pending[c] && !w_any) begin
        w_any   = 1'b1;
        w_sel   = CH_W'(c);
        w_slice = i_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A level held high while idle re-arms its own bit, so it repeats by design.
  assign w_set = (i_show & ~r_show_d) | ((r_state == ST_IDLE) ? i_show : '0);
  assign w_clr = (r_state == ST_IDLE && w_any) ? (NUM_CHANNELS'(1) << w_sel) : '0;

  // r_digits counts down; digit (r_digits-1) is the one being sent next.
  if (HEX_MODE != 0) begin : g_hex
    logic [HEX_DIGITS*4-1:0] w_pad;
    assign w_pad = (HEX_DIGITS*4)'(r_snap);
    always_comb begin
      w_char = ASCII_DIGIT_BASE;
      for (int unsigned i = 0; i < HEX_DIGITS; i++) begin
        if (DIG_W'(i + 1) == r_digits) w_char = hex_ascii(w_pad[i*4 +: 4]);
      end
    end
  end else begin : g_bin
    always_comb begin
      w_char = ASCII_DIGIT_BASE;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
        if (DIG_W'(i + 1) == r_digits) w_char = ASCII_DIGIT_BASE | {7'h00, r_snap[i]};
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_rs        = 1'b0;
    w_long      = 1'b0;
    w_byte      = 8'h00;
    case (r_state)
      ST_INIT: begin
        w_start     = 1'b1;
        w_byte      = init_byte(r_init_idx);
        w_long      = (r_init_idx == 2'd3);
        w_state_nxt = ST_EN_HIGH;
      end
      ST_IDLE: if (w_any) w_state_nxt = ST_ADDR;
      ST_ADDR: begin
        w_start     = 1'b1;
        w_byte      = chan_addr_cmd(32'(r_chan));
        w_state_nxt = ST_EN_HIGH;
      end
      ST_CHAR: begin
        w_start     = 1'b1;
        w_rs        = 1'b1;
        w_byte      = w_char;
        w_state_nxt = ST_EN_HIGH;
      end
      // Leave once the sender's enable pulse has come and gone.
      ST_EN_HIGH: if (r_en_d && !w_enable) w_state_nxt = ST_EN_LOW_WAIT;
      ST_EN_LOW_WAIT: begin
        if (w_ready) begin
          if (r_init_mode)          w_state_nxt = (r_init_idx == 2'd3) ? ST_IDLE : ST_INIT;
          else if (r_digits == '0)  w_state_nxt = ST_DONE;
          else                      w_state_nxt = ST_CHAR;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_INIT;
      r_init_mode <= 1'b1;
      r_init_idx  <= '0;
      r_pending   <= '0;
      r_show_d    <= '0;
      r_chan      <= '0;
      r_snap      <= '0;
      r_digits    <= '0;
      r_en_d      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_show_d  <= i_show;
      r_en_d    <= w_enable;
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (r_state == ST_IDLE && w_any) begin
        r_chan   <= w_sel;
        r_snap   <= w_slice;
        r_digits <= DIG_W'(NUM_DIGITS);
      end
      if (r_state == ST_CHAR) r_digits <= r_digits - DIG_W'(1);
      if (r_state == ST_EN_LOW_WAIT && w_ready && r_init_mode) begin
        if (r_init_idx == 2'd3) r_init_mode <= 1'b0;
        else                    r_init_idx  <= r_init_idx + 2'd1;
      end
    end
  end

  lcd_byte_sender #(
    .EN_HIGH_CYCLES    (EN_HIGH_CYCLES),
    .WAIT_CYCLES       (WAIT_CYCLES),
    .CLEAR_WAIT_CYCLES (CLEAR_WAIT_CYCLES)
  ) u_sender (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (w_start),
    .i_rs_in     (w_rs),
    .i_byte_in   (w_byte),
    .i_long_wait (w_long),
    .o_ready     (w_ready),
    .o_enable    (w_enable),
    .o_rs        (o_rs),
    .o_lcd_data  (o_lcd_data)
  );

  assign o_enable = w_enable;
  assign o_busy   = (r_state != ST_IDLE);
  assign o_done   = (r_state == ST_DONE) ? (NUM_CHANNELS'(1) << r_chan) : '0;
  assign o_rw     = 1'b0;
  assign o_on     = 1'b1;

endmodule
